// File: rtl/sdram_aref.sv
// sdram_aref: periodic refresh requester that issues PRECHARGE-ALL then AREF_NUM AUTO-REFRESH on grant.
// TRP_CLK and TRC_CLK must be at least 2.
module sdram_aref #(
    parameter int CNT_REF_MAX = 749,
    parameter int TRP_CLK     = 2,
    parameter int TRC_CLK     = 7,
    parameter int AREF_NUM    = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_done,
    input  logic        aref_en,
    output logic        aref_req,
    output logic [3:0]  aref_cmd,
    output logic [1:0]  aref_ba,
    output logic [11:0] aref_addr,
    output logic        aref_end
);
    localparam int CW = $clog2(CNT_REF_MAX + 1);
    localparam int TW = $clog2((TRC_CLK > TRP_CLK ? TRC_CLK : TRP_CLK) + 1);
    localparam int AW = $clog2(AREF_NUM + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_REF_MAX);
    localparam logic [TW-1:0] TRP_LAST = TW'(TRP_CLK - 2);
    localparam logic [TW-1:0] TRC_LAST = TW'(TRC_CLK - 2);
    localparam logic [AW-1:0] AREF_N   = AW'(AREF_NUM);
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PCHA = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    typedef enum logic [2:0] {S_IDLE, S_PCHA, S_TRP, S_AREF, S_TRF, S_END} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt_ref;
    logic [TW-1:0] r_tmr;
    logic [AW-1:0] r_aref_cnt;
    logic          r_req, r_end, w_grant;
    logic [3:0]    r_cmd;
    logic [1:0]    r_ba;
    logic [11:0]   r_addr;

    assign w_grant   = aref_en && r_req && r_state == S_IDLE;
    assign aref_req  = r_req;
    assign aref_cmd  = r_cmd;
    assign aref_ba   = r_ba;
    assign aref_addr = r_addr;
    assign aref_end  = r_end;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = S_PCHA;
            S_PCHA:  w_next = S_TRP;
            S_TRP:   if (r_tmr == TRP_LAST) w_next = S_AREF;
            S_AREF:  w_next = S_TRF;
            S_TRF:   if (r_tmr == TRC_LAST) w_next = (r_aref_cnt < AREF_N) ? S_AREF : S_END;
            S_END:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        r_ba   <= 2'b11;
        r_addr <= 12'hFFF;
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt_ref  <= '0;
            r_tmr      <= '0;
            r_aref_cnt <= '0;
            r_req      <= 1'b0;
            r_cmd      <= CMD_NOP;
            r_end      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt_ref  <= (!init_done || r_cnt_ref == CNT_LAST) ? '0 : r_cnt_ref + 1'b1;
            r_tmr      <= (w_next == r_state) ? r_tmr + 1'b1 : '0;
            r_aref_cnt <= (r_state == S_END) ? '0 : (r_state == S_AREF) ? r_aref_cnt + 1'b1 : r_aref_cnt;
            // an expiring interval wins over a same-cycle grant so no refresh is lost
            r_req      <= !init_done ? 1'b0 : (r_cnt_ref == CNT_LAST) ? 1'b1 : w_grant ? 1'b0 : r_req;
            r_cmd      <= (w_next == S_PCHA) ? CMD_PCHA : (w_next == S_AREF) ? CMD_AREF : CMD_NOP;
            r_end      <= w_next == S_END;
        end
    end
endmodule

// File: tb/tb_sdram_aref.sv
// tb_sdram_aref: phase table drives stimulus, a timing-formula model fills a scoreboard checked every cycle.
module tb_sdram_aref;
    localparam int MAX   = 20;
    localparam int TRP   = 2;
    localparam int TRC   = 7;
    localparam int NUM   = 2;
    localparam int END_D = 1 + TRP + NUM * TRC;

    logic        sys_clk = 1'b0, sys_rst_n = 1'b0, init_done = 1'b0, aref_en = 1'b0, d_en = 1'b0;
    logic        aref_req, aref_end, d_req, d_end;
    logic [3:0]  aref_cmd, d_cmd;
    logic [1:0]  aref_ba, d_ba;
    logic [11:0] aref_addr, d_addr;

    int   checks = 0, errors = 0;
    int   m_cnt = 0, m_d = 100;
    logic m_req = 1'b0;

    typedef struct {
        logic [19:0] val;
        string       nm;
        bit          tab;
        logic        tab_req;
        bit          dchk;
        logic        d_req;
    } ent_t;
    typedef struct {
        logic  rn, ini, en;
        int    n;
        logic  req_end;
        string nm;
    } ph_t;

    ent_t q[$];
    ent_t m_e;
    ph_t  ph[20];

    sdram_aref #(.CNT_REF_MAX(MAX), .TRP_CLK(TRP), .TRC_CLK(TRC), .AREF_NUM(NUM)) u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done), .aref_en(aref_en),
        .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr), .aref_end(aref_end)
    );

    sdram_aref u_def (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done), .aref_en(d_en),
        .aref_req(d_req), .aref_cmd(d_cmd), .aref_ba(d_ba), .aref_addr(d_addr), .aref_end(d_end)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [3:0] exp_cmd(input int d);
        exp_cmd = 4'b0111;
        if (d == 1) exp_cmd = 4'b0010;
        for (int i = 0; i < NUM; i++)
            if (d == 1 + TRP + i * TRC) exp_cmd = 4'b0001;
    endfunction

    function automatic ph_t mk(input logic rn, ini, en, input int n, input logic req_end, input string nm);
        mk.rn = rn; mk.ini = ini; mk.en = en; mk.n = n; mk.req_end = req_end; mk.nm = nm;
    endfunction

    // m_d is the cycle offset from the accepted grant; the sequence is idle once it passes END_D
    task automatic step(input logic rn, ini, en, input string nm, input bit tab, input logic treq,
                        input bit dchk, input logic dreq);
        ent_t e;
        logic acc;
        @(negedge sys_clk);
        sys_rst_n = rn;
        init_done = ini;
        aref_en   = en;
        if (!rn) begin
            m_req = 1'b0; m_cnt = 0; m_d = 100;
        end else begin
            acc   = en && m_req && m_d > END_D;
            m_d   = acc ? 1 : (m_d < 100 ? m_d + 1 : 100);
            m_req = !ini ? 1'b0 : (m_cnt == MAX) ? 1'b1 : acc ? 1'b0 : m_req;
            m_cnt = (!ini || m_cnt == MAX) ? 0 : m_cnt + 1;
        end
        e.val     = {exp_cmd(m_d), 2'b11, 12'hFFF, m_req, m_d == END_D};
        e.nm      = nm;
        e.tab     = tab;
        e.tab_req = treq;
        e.dchk    = dchk;
        e.d_req   = dreq;
        q.push_back(e);
    endtask

    always begin
        @(posedge sys_clk);
        #2;
        if (q.size() > 0) begin
            m_e = q.pop_front();
            checks++;
            if ({aref_cmd, aref_ba, aref_addr, aref_req, aref_end} !== m_e.val) begin
                errors++;
                $display("FAIL %s: {cmd,ba,addr,req,end} got %h exp %h", m_e.nm,
                         {aref_cmd, aref_ba, aref_addr, aref_req, aref_end}, m_e.val);
            end
            if (m_e.tab) begin
                checks++;
                if (aref_req !== m_e.tab_req) begin
                    errors++;
                    $display("FAIL %s_end_req: got %b exp %b", m_e.nm, aref_req, m_e.tab_req);
                end
            end
            if (m_e.dchk) begin
                checks++;
                if ({d_cmd, d_ba, d_addr, d_req, d_end} !== {4'b0111, 2'b11, 12'hFFF, m_e.d_req, 1'b0}) begin
                    errors++;
                    $display("FAIL %s: default dut got %h exp %h", m_e.nm, {d_cmd, d_ba, d_addr, d_req, d_end},
                             {4'b0111, 2'b11, 12'hFFF, m_e.d_req, 1'b0});
                end
            end
        end
    end

    initial begin
        ph[0]  = mk(1'b0, 1'b0, 1'b0,   3, 1'b0, "reset");
        ph[1]  = mk(1'b1, 1'b0, 1'b0, 100, 1'b0, "init_low");
        ph[2]  = mk(1'b1, 1'b1, 1'b0,  30, 1'b1, "first_req");
        ph[3]  = mk(1'b1, 1'b1, 1'b1,   1, 1'b0, "grant1");
        ph[4]  = mk(1'b1, 1'b1, 1'b0,  25, 1'b1, "seq1");
        ph[5]  = mk(1'b1, 1'b1, 1'b0,  60, 1'b1, "missed");
        ph[6]  = mk(1'b1, 1'b1, 1'b1,   1, 1'b0, "grant2");
        ph[7]  = mk(1'b1, 1'b1, 1'b0,  30, 1'b1, "seq2");
        ph[8]  = mk(1'b1, 1'b1, 1'b1,   1, 1'b0, "grant3");
        ph[9]  = mk(1'b1, 1'b1, 1'b0,   4, 1'b0, "pre_trf");
        ph[10] = mk(1'b1, 1'b1, 1'b1,   4, 1'b0, "spur_trf");
        ph[11] = mk(1'b1, 1'b1, 1'b0,  30, 1'b1, "post3");
        ph[12] = mk(1'b1, 1'b1, 1'b1,   1, 1'b0, "grant4");
        ph[13] = mk(1'b1, 1'b1, 1'b0,   4, 1'b1, "g4_run");
        ph[14] = mk(1'b0, 1'b1, 1'b0,   1, 1'b0, "rst_mid");
        ph[15] = mk(1'b1, 1'b0, 1'b1,   3, 1'b0, "spur_noinit");
        ph[16] = mk(1'b1, 1'b1, 1'b1,  15, 1'b0, "spur_noreq");
        ph[17] = mk(1'b1, 1'b1, 1'b0,  10, 1'b1, "req_again");
        ph[18] = mk(1'b1, 1'b1, 1'b1,   1, 1'b0, "grant5");
        ph[19] = mk(1'b1, 1'b0, 1'b0,  20, 1'b0, "init_fall");
        for (int p = 0; p < 20; p++)
            for (int c = 0; c < ph[p].n; c++)
                step(ph[p].rn, ph[p].ini, ph[p].en, ph[p].nm, c == ph[p].n - 1, ph[p].req_end, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, "def_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 760; j++)
            step(1'b1, 1'b1, 1'b0, "def_first_req", 1'b0, 1'b0, 1'b1, j >= 749);
        @(posedge sys_clk);
        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sdram_aref.md
# sdram_aref

Auto-refresh controller that sits directly downstream of `sdram_init`. It starts once `init_done` is asserted and counts the refresh interval. At each interval it raises a refresh request toward the SDRAM command arbiter. When the arbiter grants the request, it drives a PRECHARGE-ALL followed by `AREF_NUM` AUTO-REFRESH commands onto its own command/bank/address outputs, which the arbiter muxes onto the SDRAM pins.

## Interface
- `CNT_REF_MAX`, 749: refresh interval minus one, in clocks (7.5 µs at 100 MHz).
- `TRP_CLK`, 2: clocks from PRECHARGE to next command (tRP).
- `TRC_CLK`, 7: clocks from AUTO-REFRESH to next command (tRC).
- `AREF_NUM`, 2: AUTO-REFRESH commands per sequence (≥1).
- `sys_clk` in 1: system clock; all logic on its rising edge.
- `sys_rst_n` in 1: reset, synchronous and active-low.
- `init_done` in 1: from `sdram_init`; high = device initialized.
- `aref_en` in 1: grant from arbiter.
- `aref_req` out 1: refresh request to arbiter.
- `aref_cmd` out 4: {CS_n, RAS_n, CAS_n, WE_n}.
- `aref_ba` out 2: bank address.
- `aref_addr` out 12: address bus.
- `aref_end` out 1: one-cycle pulse marking end of sequence.

## Operation
- Command encodings: NOP 4'b0111, PRECHARGE 4'b0010, AUTO_REFRESH 4'b0001.
- `aref_ba` is constant 2'b11 and `aref_addr` is constant 12'hFFF. A10=1 selects precharge-all.
- All outputs are registered.

Interval counter `cnt_ref`:
- Held at 0 while `init_done`=0.
- Otherwise increments each cycle and wraps from `CNT_REF_MAX` to 0.

Request:
- `aref_req` sets on the cycle after `cnt_ref`==`CNT_REF_MAX`.
- It clears on the cycle after an accepted grant.
- Only one request is ever pending. If the interval expires again while the request is pending or a sequence is running, `aref_req` stays or sets to 1; no second request is queued.
- `init_done`=0 forces `aref_req` to 0.

Grant:
- A grant is accepted when `aref_en`=1, `aref_req`=1 and the FSM is in IDLE.
- `aref_en` is ignored in every other case.
- The counter keeps running during a sequence.

FSM states: IDLE, PCHA, TRP, AREF, TRF, END.
- IDLE → PCHA on accepted grant.
- PCHA: 1 cycle, `aref_cmd`=PRECHARGE; then TRP.
- TRP: `TRP_CLK`-1 cycles of NOP; then AREF.
- AREF: 1 cycle, `aref_cmd`=AUTO_REFRESH, refresh counter +1; then TRF.
- TRF: `TRC_CLK`-1 cycles of NOP.
  - If refresh counter < `AREF_NUM`, go back to AREF.
  - Otherwise go to END.
- END: 1 cycle, `aref_end`=1, NOP; then IDLE and clear refresh counter.
- `aref_cmd`=NOP in IDLE/TRP/TRF/END.
- An in-progress sequence runs to completion even if `init_done` falls.

## Timing
- Reset (`sys_rst_n`=0 sampled at a rising edge) sets all state on the next cycle:
  - `aref_cmd`=4'b0111, `aref_ba`=2'b11, `aref_addr`=12'hFFF;
  - `aref_req`=0, `aref_end`=0;
  - FSM in IDLE, `cnt_ref`=0, refresh counter=0.
- Reset mid-sequence aborts immediately to these values.
- First request: call cycle 0 the first cycle with `init_done`=1.
  - `cnt_ref`=k at cycle k.
  - `aref_req`=1 from cycle `CNT_REF_MAX`+1.
- Grant accepted at cycle G:
  - PRECHARGE at G+1 and `aref_req`=0 at G+1.
  - First AUTO_REFRESH at G+1+`TRP_CLK`.
  - The i-th AUTO_REFRESH (i from 0) at G+1+`TRP_CLK`+i·`TRC_CLK`.
  - `aref_end` at G+1+`TRP_CLK`+`AREF_NUM`·`TRC_CLK`.
  - IDLE one cycle later.
- Defaults: PRECHARGE G+1, AREF G+3 and G+10, `aref_end` G+17, IDLE G+18.
- Earliest next grant is one cycle after `aref_end`.

## Test plan
1. **Reset values.** Hold `sys_rst_n`=0 for 3 cycles with `init_done`=0 → `aref_cmd`=4'b0111, `aref_ba`=2'b11, `aref_addr`=12'hFFF, `aref_req`=0, `aref_end`=0. Hold `init_done`=0 for 100 cycles → `aref_req` stays 0.
2. **First request timing.** `CNT_REF_MAX`=20; raise `init_done` at cycle 0 → `aref_req` rises at cycle 21 and stays high while `aref_en`=0.
3. **Sequence timing.** Defaults, grant pulse at G → PRECHARGE at G+1, AUTO_REFRESH at G+3 and G+10, NOP elsewhere, `aref_end` high only at G+17, `aref_req` low from G+1.
4. **Missed interval.** `CNT_REF_MAX`=20; withhold `aref_en` for 60 cycles after the request, then grant once → exactly one sequence runs. `aref_req` rises again on the cycle after the next `cnt_ref`==20.
5. **Spurious grant.** Assert `aref_en` while `aref_req`=0, and again during TRF → no command other than NOP, FSM unaffected.
6. **Reset mid-sequence.** Assert reset at G+5 → reset values on the next cycle. After release and re-raising `init_done`, the first request arrives `CNT_REF_MAX`+1 cycles later.
